// File: rtl/spixel_draw_arbiter_if.sv
// rtl/spixel_draw_arbiter_if.sv - requester and engine signals of the superpixel draw arbiter
interface spixel_draw_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int SPIXEL_X_WIDTH = 5,
    parameter int SPIXEL_Y_WIDTH = 5,
    parameter int COLOR_ID_WIDTH = 8
);
    logic [NUM_REQ-1:0]                ireq;
    logic [NUM_REQ*SPIXEL_X_WIDTH-1:0] ix;
    logic [NUM_REQ*SPIXEL_Y_WIDTH-1:0] iy;
    logic [NUM_REQ*COLOR_ID_WIDTH-1:0] icolor;
    logic [NUM_REQ-1:0]                ogrant;
    logic [NUM_REQ-1:0]                odone_req;
    logic                              obusy;
    logic [SPIXEL_X_WIDTH-1:0]         ox;
    logic [SPIXEL_Y_WIDTH-1:0]         oy;
    logic [COLOR_ID_WIDTH-1:0]         ocolor;
    logic                              ovld;
    logic                              idone;
    logic                              oerr_tmo;

    modport slave (
        input  ireq, ix, iy, icolor, idone,
        output ogrant, odone_req, obusy, ox, oy, ocolor, ovld, oerr_tmo
    );

    modport master (
        output ireq, ix, iy, icolor, idone,
        input  ogrant, odone_req, obusy, ox, oy, ocolor, ovld, oerr_tmo
    );
endinterface

// File: rtl/spixel_draw_arbiter.sv
// rtl/spixel_draw_arbiter.sv - round-robin sharing of one draw_superpixel engine with done watchdog
module spixel_draw_arbiter #(
    parameter int                   NUM_REQ        = 4,
    parameter int                   SPIXEL_X_WIDTH = 5,
    parameter int                   SPIXEL_Y_WIDTH = 5,
    parameter int                   COLOR_ID_WIDTH = 8,
    parameter int                   TMO_WIDTH      = 20,
    parameter logic [TMO_WIDTH-1:0] TMO_MAX        = {TMO_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  iRST_n,
    spixel_draw_arbiter_if.slave  bus
);
    localparam int                   IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_MAX - TMO_WIDTH'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]          owner, owner_nxt;
    logic [IDX_W-1:0]          win;
    logic [TMO_WIDTH-1:0]      tmo_cnt, tmo_cnt_nxt;
    logic [NUM_REQ-1:0]        grant_nxt, done_nxt;
    logic                      vld_nxt, err_nxt;
    logic [SPIXEL_X_WIDTH-1:0] x_nxt;
    logic [SPIXEL_Y_WIDTH-1:0] y_nxt;
    logic [COLOR_ID_WIDTH-1:0] c_nxt;

    // First requester at or after ptr, wrapping around the requester ring.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign win = pick(bus.ireq, rr_ptr);

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        owner_nxt   = owner;
        tmo_cnt_nxt = tmo_cnt;
        grant_nxt   = '0;
        done_nxt    = '0;
        vld_nxt     = 1'b0;
        err_nxt     = bus.oerr_tmo;
        x_nxt       = bus.ox;
        y_nxt       = bus.oy;
        c_nxt       = bus.ocolor;
        case (state)
            S_IDLE: begin
                if (|bus.ireq) begin
                    owner_nxt = win;
                    x_nxt     = bus.ix[win*SPIXEL_X_WIDTH +: SPIXEL_X_WIDTH];
                    y_nxt     = bus.iy[win*SPIXEL_Y_WIDTH +: SPIXEL_Y_WIDTH];
                    c_nxt     = bus.icolor[win*COLOR_ID_WIDTH +: COLOR_ID_WIDTH];
                    grant_nxt = onehot(win);
                    vld_nxt   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_nxt = '0;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.idone) begin
                    done_nxt  = onehot(owner);
                    state_nxt = S_RETIRE;
                end else if (TMO_MAX != '0 && tmo_cnt == TMO_LAST) begin
                    // Engine never answered: retire anyway so the other requesters keep moving.
                    err_nxt   = 1'b1;
                    done_nxt  = onehot(owner);
                    state_nxt = S_RETIRE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_WIDTH'(1);
                end
            end
            S_RETIRE: begin
                rr_ptr_nxt = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!iRST_n) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            tmo_cnt       <= '0;
            bus.ogrant    <= '0;
            bus.odone_req <= '0;
            bus.obusy     <= 1'b0;
            bus.ox        <= '0;
            bus.oy        <= '0;
            bus.ocolor    <= '0;
            bus.ovld      <= 1'b0;
            bus.oerr_tmo  <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            owner         <= owner_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            bus.ogrant    <= grant_nxt;
            bus.odone_req <= done_nxt;
            bus.obusy     <= (state_nxt != S_IDLE);
            bus.ox        <= x_nxt;
            bus.oy        <= y_nxt;
            bus.ocolor    <= c_nxt;
            bus.ovld      <= vld_nxt;
            bus.oerr_tmo  <= err_nxt;
        end
    end
endmodule

// File: tb/tb_spixel_draw_arbiter.sv
// tb/tb_spixel_draw_arbiter.sv - self-checking bench for spixel_draw_arbiter
module tb_spixel_draw_arbiter;
    localparam int N  = 4;
    localparam int XW = 5;
    localparam int YW = 5;
    localparam int CW = 8;

    logic clk;
    logic iRST_n;

    spixel_draw_arbiter_if #(
        .NUM_REQ(N), .SPIXEL_X_WIDTH(XW), .SPIXEL_Y_WIDTH(YW), .COLOR_ID_WIDTH(CW)
    ) bus ();

    spixel_draw_arbiter #(
        .NUM_REQ(N), .SPIXEL_X_WIDTH(XW), .SPIXEL_Y_WIDTH(YW), .COLOR_ID_WIDTH(CW),
        .TMO_WIDTH(20), .TMO_MAX(20'd16)
    ) dut (
        .clk    (clk),
        .iRST_n (iRST_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             n_cmp = 0;
    int             n_bad = 0;
    int             m_ptr;
    bit             m_err;
    logic [N-1:0]   pending;
    logic [XW-1:0]  sx [N];
    logic [YW-1:0]  sy [N];
    logic [CW-1:0]  sc [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first pending requester scanning from ptr, wrapping.
    function automatic int ref_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++)
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.ix[i*XW +: XW]     = sx[i];
            bus.iy[i*YW +: YW]     = sy[i];
            bus.icolor[i*CW +: CW] = sc[i];
        end
        bus.ireq = pending;
    endtask

    task automatic newreq(input logic [N-1:0] add);
        for (int i = 0; i < N; i++) begin
            if (add[i] && !pending[i]) begin
                sx[i] = XW'($urandom);
                sy[i] = YW'($urandom);
                sc[i] = CW'($urandom);
            end
        end
        pending = pending | add;
        drive();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus.ogrant), 0);
        chk({tag, "_done"},  32'(bus.odone_req), 0);
        chk({tag, "_busy"},  32'(bus.obusy), 0);
        chk({tag, "_ox"},    32'(bus.ox), 0);
        chk({tag, "_oy"},    32'(bus.oy), 0);
        chk({tag, "_color"}, 32'(bus.ocolor), 0);
        chk({tag, "_vld"},   32'(bus.ovld), 0);
        chk({tag, "_err"},   32'(bus.oerr_tmo), 0);
    endtask

    task automatic do_reset(input string tag);
        iRST_n   = 1'b0;
        bus.idone = 1'b0;
        tick();
        check_all_zero(tag);
        tick();
        iRST_n  = 1'b1;
        m_ptr   = 0;
        m_err   = 1'b0;
        pending = '0;
        drive();
        tick();
        chk({tag, "_idle_busy"}, 32'(bus.obusy), 0);
    endtask

    // Entered with the DUT in an IDLE cycle and a nonzero pending set already driven.
    task automatic do_txn(input int delay, input bit tmo, input logic [N-1:0] readd);
        int            w;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [CW-1:0] ec;
        w  = ref_pick(pending, m_ptr);
        ex = sx[w];
        ey = sy[w];
        ec = sc[w];
        tick();
        chk("issue_grant", 32'(bus.ogrant), 32'(1) << w);
        chk("issue_vld",   32'(bus.ovld), 1);
        chk("issue_ox",    32'(bus.ox), 32'(ex));
        chk("issue_oy",    32'(bus.oy), 32'(ey));
        chk("issue_color", 32'(bus.ocolor), 32'(ec));
        chk("issue_busy",  32'(bus.obusy), 1);
        chk("issue_done",  32'(bus.odone_req), 0);
        pending[w] = 1'b0;
        newreq(readd);
        bus.idone = 1'b1;
        tick();
        bus.idone = 1'b0;
        chk("wait_vld",   32'(bus.ovld), 0);
        chk("wait_grant", 32'(bus.ogrant), 0);
        chk("wait_done",  32'(bus.odone_req), 0);
        chk("wait_busy",  32'(bus.obusy), 1);
        if (tmo) begin
            for (int k = 0; k < 15; k++) begin
                chk("tmo_wait_done", 32'(bus.odone_req), 0);
                chk("tmo_wait_err",  32'(bus.oerr_tmo), 32'(m_err));
                tick();
            end
            tick();
            m_err = 1'b1;
        end else begin
            for (int k = 0; k < delay; k++) begin
                chk("wait_hold_done", 32'(bus.odone_req), 0);
                tick();
            end
            bus.idone = 1'b1;
            tick();
            bus.idone = 1'($urandom_range(0, 1));
        end
        chk("retire_done",  32'(bus.odone_req), 32'(1) << w);
        chk("retire_err",   32'(bus.oerr_tmo), 32'(m_err));
        chk("retire_ox",    32'(bus.ox), 32'(ex));
        chk("retire_grant", 32'(bus.ogrant), 0);
        m_ptr = (w + 1) % N;
        tick();
        bus.idone = 1'b0;
        chk("idle_busy", 32'(bus.obusy), 0);
        chk("idle_done", 32'(bus.odone_req), 0);
    endtask

    initial begin
        iRST_n    = 1'b0;
        bus.idone = 1'b0;
        pending   = '0;
        for (int i = 0; i < N; i++) begin
            sx[i] = '0;
            sy[i] = '0;
            sc[i] = '0;
        end
        drive();
        tick();
        do_reset("rst0");

        // Single command from requester 0 with fixed data.
        sx[0] = 5'd3;
        sy[0] = 5'd2;
        sc[0] = 8'h0F;
        pending = 4'b0001;
        drive();
        do_txn(4, 1'b0, 4'b0000);

        // All four held: strict rotation 0,1,2,3,0.
        do_reset("rst1");
        newreq(4'b1111);
        for (int i = 0; i < 5; i++) do_txn(2, 1'b0, 4'b1111);

        // Serve req2 only, then 1001: req3 wins before req0.
        do_reset("rst2");
        newreq(4'b0100);
        do_txn(1, 1'b0, 4'b0000);
        newreq(4'b1001);
        do_txn(0, 1'b0, 4'b0000);
        do_txn(3, 1'b0, 4'b0000);

        // Watchdog: no done ever, then a normal request still served.
        newreq(4'b0010);
        do_txn(0, 1'b1, 4'b0000);
        newreq(4'b1000);
        do_txn(2, 1'b0, 4'b0000);

        // Reset while waiting for done: command dropped, no completion pulse.
        newreq(4'b0100);
        tick();
        pending = '0;
        drive();
        tick();
        tick();
        do_reset("rst_wait");
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_done", 32'(bus.odone_req), 0);
            tick();
        end
        newreq(4'b0010);
        do_txn(1, 1'b0, 4'b0000);

        // Stray done while idle.
        for (int k = 0; k < 4; k++) begin
            bus.idone = 1'($urandom_range(0, 1));
            tick();
            chk("idle_stray_busy", 32'(bus.obusy), 0);
            chk("idle_stray_done", 32'(bus.odone_req), 0);
        end
        bus.idone = 1'b0;

        // Randomised traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            if (pending == '0) newreq(N'($urandom_range(1, 15)));
            do_txn(int'($urandom_range(0, 6)), ($urandom_range(0, 9) == 0),
                   N'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
